// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the round-robin VC arbiter: state encoding, index-width helper
// and the default FIFO geometry used by the arbiter and its neighbouring blocks.
package arbitro_rr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } arb_state_t;

  localparam int NUM_VC_DEFAULT     = 4;
  localparam int DATA_WIDTH_DEFAULT = 6;
  localparam int MAX_BURST_DEFAULT  = 2;

  // Index width for a VC number; never narrower than one bit.
  function automatic int vc_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_rr_picker.sv
// Combinational rotating-priority picker: first requester strictly after the pointer,
// wrapping around so the pointer position itself has the lowest priority.
module rr_priority_picker
  import arbitro_rr_pkg::*;
#(
  parameter int N  = NUM_VC_DEFAULT,
  parameter int IW = vc_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  logic [IW-1:0] w_cand;

  // N is a power of two, so the IW-bit sum wraps exactly modulo N.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    w_cand = '0;
    for (int i = 1; i <= N; i++) begin
      w_cand = i_ptr + IW'(i);
      if (!o_vld && i_req[w_cand]) begin
        o_vld         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter draining NUM_VC input FIFOs into one output FIFO, holding each
// grant for up to MAX_BURST pops; pops are combinational, the push side is registered.
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int NUM_VC     = NUM_VC_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int MAX_BURST  = MAX_BURST_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         active,
  input  logic [NUM_VC-1:0]            empty_vc,
  input  logic [NUM_VC*DATA_WIDTH-1:0] rd_data_vc,
  input  logic                         almost_full,
  output logic [NUM_VC-1:0]            pop_vc,
  output logic                         push_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [$clog2(NUM_VC)-1:0]    grant_id,
  output logic                         idle
);

  localparam int                IDX_W     = vc_idx_w(NUM_VC);
  localparam int                CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0]  PTR_RESET = IDX_W'(NUM_VC - 1);

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_grant;
  logic [IDX_W-1:0]       r_ptr;
  logic [CNT_W-1:0]       r_burst;
  logic                   r_push;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_idle;

  logic [NUM_VC-1:0]      w_req;
  logic                   w_can_pop;
  logic                   w_serving;
  logic [IDX_W-1:0]       w_pick_ptr;
  logic [NUM_VC-1:0]      w_pick_gnt;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_vld;
  logic                   w_same_ok;
  logic                   w_pop_same;
  logic                   w_pop_new;
  logic                   w_pop_any;
  logic [IDX_W-1:0]       w_pop_idx;
  logic [DATA_WIDTH-1:0]  w_pop_word;

  assign w_req     = ~empty_vc;
  assign w_can_pop = active & ~almost_full & ~reset;
  assign w_serving = (r_state == ST_SERVE);

  // While serving, rotation searches after the current grant so the next VC is
  // chosen in the same cycle the burst ends.
  assign w_pick_ptr = w_serving ? r_grant : r_ptr;

  rr_priority_picker #(
    .N  (NUM_VC),
    .IW (IDX_W)
  ) u_picker (
    .i_req (w_req),
    .i_ptr (w_pick_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  assign w_same_ok  = w_serving & w_req[r_grant] & (r_burst < BURST_MAX);
  assign w_pop_same = w_can_pop & w_same_ok;
  assign w_pop_new  = w_can_pop & ~w_same_ok & w_pick_vld;
  assign w_pop_any  = w_pop_same | w_pop_new;
  assign w_pop_idx  = w_pop_same ? r_grant : w_pick_idx;
  assign w_pop_word = rd_data_vc[int'(w_pop_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    pop_vc = '0;
    if (w_pop_same) begin
      pop_vc[r_grant] = 1'b1;
    end else if (w_pop_new) begin
      pop_vc = w_pick_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_burst <= '0;
      r_ptr   <= PTR_RESET;
      r_push  <= 1'b0;
      r_data  <= '0;
      r_idle  <= 1'b1;
    end else begin
      // The push stage always completes a pop already issued, whatever active does.
      r_push <= w_pop_any;
      if (w_pop_any) begin
        r_data <= w_pop_word;
      end
      r_idle <= ~w_serving & ~r_push;

      if (!active) begin
        if (w_serving) begin
          r_ptr <= r_grant;
        end
        r_state <= ST_IDLE;
        r_burst <= '0;
      end else if (w_pop_same) begin
        r_burst <= r_burst + CNT_W'(1);
      end else if (w_pop_new) begin
        if (w_serving) begin
          r_ptr <= r_grant;
        end
        r_grant <= w_pick_idx;
        r_burst <= CNT_W'(1);
        r_state <= ST_SERVE;
      end else if (w_serving && !almost_full) begin
        // Burst over or VC drained and nobody else is waiting.
        r_ptr   <= r_grant;
        r_state <= ST_IDLE;
        r_burst <= '0;
      end
    end
  end

  assign push_out = r_push;
  assign data_out = r_data;
  assign grant_id = r_grant;
  assign idle     = r_idle;

endmodule

// File: tb/tb_arbitro_rr.sv
// Bench for arbitro_rr: directed scenarios with literal expectations plus a randomized
// run checked against a cycle-level behavioural model of the arbitration rules.
module tb_arbitro_rr;

  localparam int NUM_VC    = 4;
  localparam int DW        = 6;
  localparam int MAX_BURST = 2;
  localparam int IW        = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   active;
  logic                   almost_full;
  logic [NUM_VC-1:0]      empty_vc;
  logic [NUM_VC*DW-1:0]   rd_data_vc;
  logic [NUM_VC-1:0]      pop_vc;
  logic                   push_out;
  logic [DW-1:0]          data_out;
  logic [IW-1:0]          grant_id;
  logic                   idle;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_hold;
  int          m_vc;
  int          m_cnt;
  int          m_ptr;
  int          m_pop;
  bit          m_same;
  bit          m_push;
  bit          m_idle;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  arbitro_rr #(
    .NUM_VC     (NUM_VC),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .empty_vc    (empty_vc),
    .rd_data_vc  (rd_data_vc),
    .almost_full (almost_full),
    .pop_vc      (pop_vc),
    .push_out    (push_out),
    .data_out    (data_out),
    .grant_id    (grant_id),
    .idle        (idle)
  );

  function automatic int first_after(int after);
    for (int i = 1; i <= NUM_VC; i++) begin
      int k;
      k = (after + i) % NUM_VC;
      if (!empty_vc[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] word_of(int k);
    return rd_data_vc[k*DW +: DW];
  endfunction

  function automatic logic [NUM_VC-1:0] onehot(int k);
    logic [NUM_VC-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  task automatic model_eval();
    m_pop  = -1;
    m_same = 1'b0;
    if (active && !almost_full && !reset) begin
      if (m_hold && !empty_vc[m_vc] && m_cnt < MAX_BURST) begin
        m_pop  = m_vc;
        m_same = 1'b1;
      end else begin
        m_pop = first_after(m_hold ? m_vc : m_ptr);
      end
    end
  endtask

  task automatic model_clock();
    bit was_idle;
    if (reset) begin
      m_hold = 1'b0; m_vc = 0; m_cnt = 0; m_ptr = NUM_VC - 1;
      m_push = 1'b0; m_data = '0; m_idle = 1'b1;
    end else begin
      was_idle = !m_hold && !m_push;
      m_push = (m_pop >= 0);
      if (m_push) m_data = word_of(m_pop);
      if (!active) begin
        if (m_hold) m_ptr = m_vc;
        m_hold = 1'b0; m_cnt = 0;
      end else if (m_same) begin
        m_cnt++;
      end else if (m_pop >= 0) begin
        if (m_hold) m_ptr = m_vc;
        m_vc = m_pop; m_cnt = 1; m_hold = 1'b1;
      end else if (m_hold && !almost_full) begin
        m_ptr = m_vc; m_hold = 1'b0; m_cnt = 0;
      end
      m_idle = was_idle;
    end
  endtask

  task automatic advance();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_eval();
    advance();
    reset = 1'b0;
  endtask

  task automatic settle();
    active = 1'b0;
    almost_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      model_eval();
      advance();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; active = 1'b0; almost_full = 1'b0; empty_vc = '1; rd_data_vc = '0;
    model_eval();
    advance();
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin active = 1'b1; empty_vc = '0; rd_data_vc = {$urandom}; end
      model_eval();
      @(negedge clk);
      checks++; if (pop_vc !== '0) begin errors++; $display("FAIL reset_pop_vc cyc%0d: got %b expected 0000", c, pop_vc); end
      checks++; if (push_out !== 1'b0) begin errors++; $display("FAIL reset_push_out cyc%0d: got %b expected 0", c, push_out); end
      checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out cyc%0d: got %h expected 0", c, data_out); end
      checks++; if (grant_id !== '0) begin errors++; $display("FAIL reset_grant_id cyc%0d: got %0d expected 0", c, grant_id); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle cyc%0d: got %b expected 1", c, idle); end
      advance();
    end
    reset = 1'b0; active = 1'b0; empty_vc = '1;
  endtask

  task automatic test_round_robin();
    int exp_pop [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    do_reset();
    rd_data_vc = {$urandom}; active = 1'b1; almost_full = 1'b0; empty_vc = '0;
    for (int i = 0; i < 9; i++) begin
      model_eval();
      @(negedge clk);
      checks++; if (pop_vc !== onehot(exp_pop[i])) begin errors++; $display("FAIL rr_pop_vc cyc%0d: got %b expected %b", i, pop_vc, onehot(exp_pop[i])); end
      if (i > 0) begin
        checks++; if (push_out !== 1'b1) begin errors++; $display("FAIL rr_push_out cyc%0d: got %b expected 1", i, push_out); end
        checks++; if (data_out !== word_of(exp_pop[i-1])) begin errors++; $display("FAIL rr_data_out cyc%0d: got %h expected %h", i, data_out, word_of(exp_pop[i-1])); end
        checks++; if (grant_id !== IW'(exp_pop[i-1])) begin errors++; $display("FAIL rr_grant_id cyc%0d: got %0d expected %0d", i, grant_id, exp_pop[i-1]); end
      end
      advance();
    end
    settle();
  endtask

  task automatic test_single_vc();
    do_reset();
    rd_data_vc = {$urandom}; active = 1'b1; almost_full = 1'b0; empty_vc = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      model_eval();
      @(negedge clk);
      checks++; if (pop_vc !== 4'b0100) begin errors++; $display("FAIL single_pop_vc cyc%0d: got %b expected 0100", i, pop_vc); end
      if (i > 0) begin
        checks++; if (push_out !== 1'b1) begin errors++; $display("FAIL single_push_out cyc%0d: got %b expected 1", i, push_out); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id cyc%0d: got %0d expected 2", i, grant_id); end
      end
      advance();
    end
    settle();
  endtask

  task automatic test_almost_full();
    bit af_sched [7] = '{0, 0, 0, 1, 1, 0, 0};
    int exp_pop  [7] = '{0, 0, 1, -1, -1, 1, 2};
    int exp_gnt  [7] = '{0, 0, 0, 1, 1, 1, 1};
    do_reset();
    rd_data_vc = {$urandom}; active = 1'b1; empty_vc = '0;
    for (int i = 0; i < 7; i++) begin
      almost_full = af_sched[i];
      model_eval();
      @(negedge clk);
      checks++; if (pop_vc !== onehot(exp_pop[i])) begin errors++; $display("FAIL af_pop_vc cyc%0d: got %b expected %b", i, pop_vc, onehot(exp_pop[i])); end
      if (i > 0) begin
        checks++; if (push_out !== (exp_pop[i-1] >= 0)) begin errors++; $display("FAIL af_push_out cyc%0d: got %b expected %b", i, push_out, exp_pop[i-1] >= 0); end
        if (exp_pop[i-1] >= 0) begin
          checks++; if (data_out !== word_of(exp_pop[i-1])) begin errors++; $display("FAIL af_data_out cyc%0d: got %h expected %h", i, data_out, word_of(exp_pop[i-1])); end
        end
        checks++; if (grant_id !== IW'(exp_gnt[i])) begin errors++; $display("FAIL af_grant_id cyc%0d: got %0d expected %0d", i, grant_id, exp_gnt[i]); end
      end
      advance();
    end
    settle();
  endtask

  task automatic test_active_drop();
    do_reset();
    rd_data_vc = {$urandom}; active = 1'b1; almost_full = 1'b0; empty_vc = '0;
    for (int i = 0; i < 3; i++) begin
      model_eval();
      advance();
    end
    active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      model_eval();
      @(negedge clk);
      checks++; if (pop_vc !== '0) begin errors++; $display("FAIL drop_pop_vc cyc%0d: got %b expected 0000", i, pop_vc); end
      checks++; if (push_out !== (i == 0)) begin errors++; $display("FAIL drop_push_out cyc%0d: got %b expected %b", i, push_out, i == 0); end
      checks++; if (idle !== (i == 2)) begin errors++; $display("FAIL drop_idle cyc%0d: got %b expected %b", i, idle, i == 2); end
      if (i == 0) begin
        checks++; if (data_out !== word_of(1)) begin errors++; $display("FAIL drop_data_out: got %h expected %h", data_out, word_of(1)); end
      end
      advance();
    end
    settle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rd_data_vc = {$urandom}; active = 1'b1; almost_full = 1'b0; empty_vc = '0;
    for (int i = 0; i < 7; i++) begin
      model_eval();
      @(negedge clk);
      if (i == 6) begin
        checks++; if (pop_vc !== 4'b1000) begin errors++; $display("FAIL mid_pop_vc3: got %b expected 1000", pop_vc); end
      end
      advance();
    end
    reset = 1'b1;
    model_eval();
    @(negedge clk);
    checks++; if (pop_vc !== '0) begin errors++; $display("FAIL mid_reset_pop_vc: got %b expected 0000", pop_vc); end
    checks++; if (push_out !== 1'b1) begin errors++; $display("FAIL mid_reset_inflight: got %b expected 1", push_out); end
    advance();
    reset = 1'b0;
    model_eval();
    @(negedge clk);
    checks++; if (push_out !== 1'b0) begin errors++; $display("FAIL mid_after_push_out: got %b expected 0", push_out); end
    checks++; if (grant_id !== '0) begin errors++; $display("FAIL mid_after_grant_id: got %0d expected 0", grant_id); end
    checks++; if (pop_vc !== 4'b0001) begin errors++; $display("FAIL mid_after_first_grant: got %b expected 0001", pop_vc); end
    advance();
    settle();
  endtask

  task automatic test_random();
    int prev_pop = -1;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (prev_pop < 0) rd_data_vc = {$urandom};
      reset       = ($urandom_range(0, 99) < 2);
      active      = ($urandom_range(0, 9) != 0);
      almost_full = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < NUM_VC; k++) empty_vc[k] = ($urandom_range(0, 2) == 0);
      model_eval();
      @(negedge clk);
      checks++; if (pop_vc !== onehot(m_pop)) begin errors++; $display("FAIL rnd_pop_vc n%0d: got %b expected %b", n, pop_vc, onehot(m_pop)); end
      checks++; if (push_out !== m_push) begin errors++; $display("FAIL rnd_push_out n%0d: got %b expected %b", n, push_out, m_push); end
      if (m_push) begin
        checks++; if (data_out !== m_data) begin errors++; $display("FAIL rnd_data_out n%0d: got %h expected %h", n, data_out, m_data); end
      end
      checks++; if (grant_id !== IW'(m_vc)) begin errors++; $display("FAIL rnd_grant_id n%0d: got %0d expected %0d", n, grant_id, m_vc); end
      checks++; if (idle !== m_idle) begin errors++; $display("FAIL rnd_idle n%0d: got %b expected %b", n, idle, m_idle); end
      prev_pop = m_pop;
      advance();
    end
    reset = 1'b0;
    settle();
  endtask

  initial begin
    reset = 1'b1; active = 1'b0; almost_full = 1'b0; empty_vc = '1; rd_data_vc = '0;
    m_hold = 1'b0; m_vc = 0; m_cnt = 0; m_ptr = NUM_VC - 1; m_pop = -1; m_same = 1'b0;
    m_push = 1'b0; m_data = '0; m_idle = 1'b1;
    test_reset();
    test_round_robin();
    test_single_vc();
    test_almost_full();
    test_active_drop();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
